// File: rtl/rv32i_fetch_unit.sv
// rtl/rv32i_fetch_unit.sv - RV32I instruction prefetch unit with credit-limited FIFO and redirect flush
// Optional FETCH_MISALIGN_CHECK_EN: misaligned redirect targets halt fetch and raise fetch_fault.
module rv32i_fetch_unit #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] mem_addr,
  output logic        mem_re,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rvalid,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_data,
  output logic [31:0] instr_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        fetch_fault
);

  localparam int             AW      = $clog2(DEPTH);
  localparam logic [AW:0]    DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW-1:0]  PTR_ONE = AW'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_DRAIN = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [31:0]   r_fetch_pc;
  logic [31:0]   w_fetch_pc_nxt;
  logic [31:0]   r_mem_addr;
  logic          r_mem_re;
  logic [31:0]   r_fifo_data [DEPTH];
  logic [31:0]   r_fifo_pc   [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic [AW:0]   w_count_nxt;
  logic          w_push;
  logic          w_pop;
  logic          w_flush;
  logic          w_issue;
  logic          w_go_idle;
  logic          w_misalign;
  logic [31:0]   w_redir_pc;
  logic [31:0]   w_base_pc;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic r_fault;

  assign w_redir_pc  = redirect_pc;
  assign w_misalign  = redirect_valid && (redirect_pc[1:0] != 2'b00);
  assign fetch_fault = r_fault;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fault <= 1'b0;
    end else if (w_state_nxt == S_HALT) begin
      r_fault <= 1'b1;
    end
  end
`else
  logic w_unused_lsbs;

  assign w_redir_pc    = {redirect_pc[31:2], 2'b00};
  assign w_misalign    = 1'b0;
  assign w_unused_lsbs = ^redirect_pc[1:0];
  assign fetch_fault   = 1'b0;
`endif

  assign instr_valid = (r_count != '0);
  assign w_pop       = instr_valid && instr_ready;
  assign instr_data  = instr_valid ? r_fifo_data[r_rd_ptr] : 32'h0;
  assign instr_pc    = instr_valid ? r_fifo_pc[r_rd_ptr]   : 32'h0;
  assign mem_addr    = r_mem_addr;
  assign mem_re      = r_mem_re;

  // A redirect both supplies the next fetch address and kills any in-flight response.
  always_comb begin
    w_state_nxt    = r_state;
    w_fetch_pc_nxt = r_fetch_pc;
    w_push         = 1'b0;
    w_flush        = redirect_valid;
    w_go_idle      = 1'b0;
    w_issue        = 1'b0;
    w_base_pc      = redirect_valid ? w_redir_pc : r_fetch_pc;

    case (r_state)
      S_IDLE: begin
        w_go_idle = 1'b1;
      end
      S_WAIT: begin
        if (mem_rvalid) begin
          w_push    = !redirect_valid;
          w_go_idle = 1'b1;
        end else if (redirect_valid) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (mem_rvalid) begin
          w_go_idle = 1'b1;
        end
      end
      S_HALT: begin
        w_go_idle = 1'b0;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    if (w_misalign && (r_state != S_HALT)) begin
      w_state_nxt = S_HALT;
      w_go_idle   = 1'b0;
      w_push      = 1'b0;
    end else if (redirect_valid) begin
      w_fetch_pc_nxt = w_redir_pc;
    end

    if (w_flush) begin
      w_count_nxt = '0;
    end else begin
      w_count_nxt = r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
    end

    // Issue only when the entry this request will fill is already free.
    if (w_go_idle) begin
      if (w_count_nxt < DEPTH_C) begin
        w_issue        = 1'b1;
        w_state_nxt    = S_WAIT;
        w_fetch_pc_nxt = w_base_pc + 32'd4;
      end else begin
        w_state_nxt = S_IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc <= RESET_PC;
      r_mem_addr <= 32'h0;
      r_mem_re   <= 1'b0;
      r_count    <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
    end else begin
      r_fetch_pc <= w_fetch_pc_nxt;
      r_mem_re   <= w_issue;
      r_count    <= w_count_nxt;
      if (w_issue) begin
        r_mem_addr <= w_base_pc;
      end
      if (w_flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_push) begin
          r_wr_ptr <= r_wr_ptr + PTR_ONE;
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + PTR_ONE;
        end
      end
    end
  end

  // mem_addr still holds the address of the single outstanding request when its data returns.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_data[r_wr_ptr] <= mem_rdata;
      r_fifo_pc[r_wr_ptr]   <= r_mem_addr;
    end
  end

endmodule
